adat_frame_writer: RTL and testbench

ADAT_FRAME_WRITER -- requirements
Module: adat_frame_writer

---
 rtl/adat_frame_writer.sv | 213 +++++++++++++++++++++
 tb/tb_adat_frame_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_frame_writer.sv
// rtl/adat_frame_writer.sv - writes 8-channel 24-bit ADAT sample frames bit-serially into a circular frame RAM
//
// Purpose:
//   Accepts one 24-bit sample at a time, tracks its channel position within an
//   8-channel frame and writes it MSB-first into the frame slot W of a circular
//   bit-wide RAM, one bit per cycle. A frame slot is published through
//   last_good_frame_idx_o only once all 8 channels have been written. If slot W
//   is still being read when a new frame starts, the whole frame is discarded.
//
// Ports:
//   clk_i                 sole clock, rising edge
//   rst_i                 synchronous active-high reset
//   sample_i              24-bit audio sample, MSB = bit 23
//   sample_valid_i        sample_i is valid
//   sample_first_i        sample_i is channel 0 of a frame
//   sample_ready_o        block accepts a sample this cycle
//   reader_frame_i        frame slot the encoder is currently reading
//   ram_write_addr_o      {frame, channel[2:0], bit_idx[4:0]}
//   ram_write_data_o      RAM write bit
//   ram_write_en_o        RAM write strobe
//   last_good_frame_idx_o newest fully written frame slot
//   frame_dropped_o       one-cycle pulse, frame discarded because the buffer is full
//   sync_error_o          one-cycle pulse, channel framing error
//   overflow_count_o      saturating count of drop/sync pulses
//                         (only with ADAT_WRITER_OVERFLOW_CNT_EN defined)

module adat_frame_writer #(
  parameter int CIRC_BUF_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [23:0]                sample_i,
  input  logic                       sample_valid_i,
  input  logic                       sample_first_i,
  output logic                       sample_ready_o,
  input  logic [CIRC_BUF_BITS-1:0]   reader_frame_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_write_addr_o,
  output logic                       ram_write_data_o,
  output logic                       ram_write_en_o,
  output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
  output logic                       frame_dropped_o,
`ifdef ADAT_WRITER_OVERFLOW_CNT_EN
  output logic [7:0]                 overflow_count_o,
`endif
  output logic                       sync_error_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShift   = 2'd1,
    StDiscard = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 ch_q, ch_d;
  logic [CIRC_BUF_BITS-1:0]   w_q, w_d;
  logic [CIRC_BUF_BITS-1:0]   lg_q, lg_d;
  logic [4:0]                 k_q, k_d;
  logic [23:0]                shreg_q, shreg_d;
  logic [CIRC_BUF_BITS+7:0]   addr_q, addr_d;
  logic                       data_q, data_d;
  logic                       we_q, we_d;
  logic                       drop_q, drop_d;
  logic                       sync_q, sync_d;
  logic                       discard_q, discard_d;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    w_d       = w_q;
    lg_d      = lg_q;
    k_d       = k_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    drop_d    = 1'b0;
    sync_d    = 1'b0;
    discard_d = discard_q;

    case (state_q)
      StIdle: begin
        if (sample_valid_i) begin
          if (sample_first_i) begin
            // A frame start always restarts channel 0 of slot W; any partial
            // frame is abandoned and the buffer-full check is redone here only.
            sync_d = (ch_q != 3'd0);
            if (w_q == reader_frame_i) begin
              discard_d = 1'b1;
              ch_d      = 3'd1;
              state_d   = StDiscard;
            end else begin
              discard_d = 1'b0;
              ch_d      = 3'd0;
              state_d   = StShift;
              we_d      = 1'b1;
              k_d       = 5'd0;
              addr_d    = {w_q, 3'd0, 5'd0};
              data_d    = sample_i[23];
              shreg_d   = {sample_i[22:0], 1'b0};
            end
          end else if (ch_q == 3'd0) begin
            // Stray sample where a frame start was expected: drop it.
            sync_d = 1'b1;
          end else if (discard_q) begin
            state_d = StDiscard;
            if (ch_q == 3'd7) begin
              drop_d    = 1'b1;
              discard_d = 1'b0;
              ch_d      = 3'd0;
            end else begin
              ch_d = ch_q + 3'd1;
            end
          end else begin
            state_d = StShift;
            we_d    = 1'b1;
            k_d     = 5'd0;
            addr_d  = {w_q, ch_q, 5'd0};
            data_d  = sample_i[23];
            shreg_d = {sample_i[22:0], 1'b0};
          end
        end
      end

      StShift: begin
        // k_q is the bit index currently presented on the RAM port.
        if (k_q == 5'd23) begin
          state_d = StIdle;
          if (ch_q == 3'd7) begin
            lg_d = w_q;
            w_d  = w_q + CIRC_BUF_BITS'(1);
            ch_d = 3'd0;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end else begin
          we_d    = 1'b1;
          k_d     = k_q + 5'd1;
          addr_d  = {w_q, ch_q, k_q + 5'd1};
          data_d  = shreg_q[23];
          shreg_d = {shreg_q[22:0], 1'b0};
        end
      end

      StDiscard: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef ADAT_WRITER_OVERFLOW_CNT_EN
  logic [7:0] ovf_q, ovf_d;
  logic [8:0] ovf_sum;

  always_comb begin
    ovf_sum = {1'b0, ovf_q} + 9'(drop_d) + 9'(sync_d);
    ovf_d   = (ovf_sum > 9'd255) ? 8'hFF : ovf_sum[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 8'd0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_count_o = ovf_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ch_q      <= 3'd0;
      w_q       <= CIRC_BUF_BITS'(1);
      lg_q      <= '0;
      k_q       <= 5'd0;
      shreg_q   <= 24'd0;
      addr_q    <= '0;
      data_q    <= 1'b0;
      we_q      <= 1'b0;
      drop_q    <= 1'b0;
      sync_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      w_q       <= w_d;
      lg_q      <= lg_d;
      k_q       <= k_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      drop_q    <= drop_d;
      sync_q    <= sync_d;
      discard_q <= discard_d;
    end
  end

  assign sample_ready_o        = (state_q == StIdle);
  assign ram_write_addr_o      = addr_q;
  assign ram_write_data_o      = data_q;
  assign ram_write_en_o        = we_q;
  assign last_good_frame_idx_o = lg_q;
  assign frame_dropped_o       = drop_q;
  assign sync_error_o          = sync_q;

endmodule

// File: tb/tb_adat_frame_writer.sv
// tb/tb_adat_frame_writer.sv - self-checking bench for adat_frame_writer
module tb_adat_frame_writer;
  localparam int CB = 3;
  localparam int AW = CB + 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [23:0]   sample_i = 24'd0;
  logic          sample_valid_i = 1'b0;
  logic          sample_first_i = 1'b0;
  logic          sample_ready_o;
  logic [CB-1:0] reader_frame_i = '0;
  logic [AW-1:0] ram_write_addr_o;
  logic          ram_write_data_o;
  logic          ram_write_en_o;
  logic [CB-1:0] last_good_frame_idx_o;
  logic          frame_dropped_o;
  logic          sync_error_o;
`ifdef ADAT_WRITER_OVERFLOW_CNT_EN
  logic [7:0]    overflow_count_o;
`endif

  always #5 clk_i = ~clk_i;

  adat_frame_writer #(.CIRC_BUF_BITS(CB)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .sample_i              (sample_i),
    .sample_valid_i        (sample_valid_i),
    .sample_first_i        (sample_first_i),
    .sample_ready_o        (sample_ready_o),
    .reader_frame_i        (reader_frame_i),
    .ram_write_addr_o      (ram_write_addr_o),
    .ram_write_data_o      (ram_write_data_o),
    .ram_write_en_o        (ram_write_en_o),
    .last_good_frame_idx_o (last_good_frame_idx_o),
    .frame_dropped_o       (frame_dropped_o),
`ifdef ADAT_WRITER_OVERFLOW_CNT_EN
    .overflow_count_o      (overflow_count_o),
`endif
    .sync_error_o          (sync_error_o)
  );

  int passed = 0;
  int total  = 0;

  // Observed RAM writes {addr, data} and pulse counts.
  logic [AW:0] got_q[$];
  int drop_seen = 0;
  int sync_seen = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (ram_write_en_o) got_q.push_back({ram_write_addr_o, ram_write_data_o});
      if (frame_dropped_o) drop_seen++;
      if (sync_error_o) sync_seen++;
    end
  end

  // Sample-level reference model.
  int  m_ch, m_w, m_lg, m_drop, m_sync;
  bit  m_disc;
  logic [AW:0] exp_q[$];
  int  g_base, d_base, s_base;

  task automatic model_accept(input logic [23:0] d, input bit first, input int reader);
    if (first) begin
      if (m_ch != 0) m_sync++;
      m_ch   = 0;
      m_disc = (m_w == reader);
    end else if (m_ch == 0) begin
      m_sync++;
      return;
    end
    if (m_disc) begin
      if (m_ch == 7) begin
        m_drop++;
        m_ch   = 0;
        m_disc = 0;
      end else m_ch++;
    end else begin
      for (int k = 0; k < 24; k++)
        exp_q.push_back({CB'(m_w), 3'(m_ch), 5'(k), d[23-k]});
      if (m_ch == 7) begin
        m_lg = m_w;
        m_w  = (m_w + 1) % (1 << CB);
        m_ch = 0;
      end else m_ch++;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sample_valid_i = 1'b0;
    sample_first_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i  = 1'b0;
    m_ch = 0; m_w = 1; m_lg = 0; m_disc = 0; m_drop = 0; m_sync = 0;
    exp_q.delete();
    g_base = got_q.size();
    d_base = drop_seen;
    s_base = sync_seen;
  endtask

  task automatic send_sample(input logic [23:0] d, input bit first, input int reader);
    int n;
    @(negedge clk_i);
    sample_i       = d;
    sample_first_i = first;
    reader_frame_i = CB'(reader);
    sample_valid_i = 1'b1;
    n = 0;
    while (!sample_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL handshake_timeout: ready=%0b after %0d cycles, required 1", sample_ready_o, n);
      sample_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    model_accept(d, first, reader);
    #1 sample_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk_i); #1;
    while (!sample_ready_o && n < 200) begin
      @(negedge clk_i); #1;
      n++;
    end
    @(negedge clk_i); #1;
    if (n >= 200) begin
      total++;
      $display("FAIL idle_timeout: ready=%0b, required 1", sample_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    sample_valid_i = 1'b1;
    sample_first_i = 1'b1;
    sample_i = 24'h123456;
    reader_frame_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    total++; if (sample_ready_o !== 1'b1) $display("FAIL reset_ready: got %0b want 1", sample_ready_o); else passed++;
    total++; if (ram_write_en_o !== 1'b0) $display("FAIL reset_we: got %0b want 0", ram_write_en_o); else passed++;
    total++; if (last_good_frame_idx_o !== CB'(0)) $display("FAIL reset_last_good: got %0d want 0", last_good_frame_idx_o); else passed++;
    total++; if ({frame_dropped_o, sync_error_o} !== 2'b00) $display("FAIL reset_pulses: got %b want 00", {frame_dropped_o, sync_error_o}); else passed++;
    do_reset();
  endtask

  task automatic test_single_frame();
    int mism, fi;
    do_reset();
    for (int ch = 0; ch < 8; ch++) send_sample(24'hA00000 + 24'(ch), ch == 0, 0);
    wait_idle();
    total++; if (got_q.size() - g_base !== 192) $display("FAIL single_write_count: got %0d want 192", got_q.size() - g_base); else passed++;
    mism = 0; fi = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (g_base + i >= got_q.size() || got_q[g_base + i] !== exp_q[i]) begin
        if (mism == 0) fi = i;
        mism++;
      end
    total++;
    if (mism != 0) $display("FAIL single_write_data: %0d bad, first at %0d got %h want %h", mism, fi,
                            (g_base + fi < got_q.size()) ? got_q[g_base + fi] : 'x, exp_q[fi]);
    else passed++;
    total++; if (last_good_frame_idx_o !== CB'(1)) $display("FAIL single_last_good: got %0d want 1", last_good_frame_idx_o); else passed++;
  endtask

  task automatic test_wrap();
    int mism, b;
    do_reset();
    mism = 0;
    for (int f = 0; f < 8; f++) begin
      for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, m_lg);
      wait_idle();
      total++;
      if (last_good_frame_idx_o !== CB'((f + 1) % 8))
        $display("FAIL wrap_last_good_%0d: got %0d want %0d", f, last_good_frame_idx_o, (f + 1) % 8);
      else passed++;
    end
    b = got_q.size();
    for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, m_lg);
    wait_idle();
    total++;
    if (b >= got_q.size() || got_q[b][AW -: CB] !== CB'(1))
      $display("FAIL wrap_slot: got %0d want 1", (b < got_q.size()) ? got_q[b][AW -: CB] : 'x);
    else passed++;
    for (int i = 0; i < exp_q.size(); i++)
      if (g_base + i >= got_q.size() || got_q[g_base + i] !== exp_q[i]) mism++;
    total++;
    if (mism != 0 || got_q.size() - g_base != exp_q.size())
      $display("FAIL wrap_writes: %0d bad of %0d, count got %0d want %0d", mism, exp_q.size(), got_q.size() - g_base, exp_q.size());
    else passed++;
  endtask

  task automatic test_discard();
    int b, c0, mism;
    do_reset();
    for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, 0);
    wait_idle();
    b  = got_q.size();
    c0 = cyc;
    for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, 2);
    total++; if (cyc - c0 > 32) $display("FAIL discard_latency: got %0d cycles want <= 32", cyc - c0); else passed++;
    wait_idle();
    total++; if (got_q.size() !== b) $display("FAIL discard_writes: got %0d want 0", got_q.size() - b); else passed++;
    total++; if (drop_seen - d_base !== 1) $display("FAIL discard_dropped: got %0d want 1", drop_seen - d_base); else passed++;
    total++; if (last_good_frame_idx_o !== CB'(1)) $display("FAIL discard_last_good: got %0d want 1", last_good_frame_idx_o); else passed++;
    for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, 0);
    wait_idle();
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (g_base + i >= got_q.size() || got_q[g_base + i] !== exp_q[i]) mism++;
    total++;
    if (mism != 0 || got_q.size() - g_base != exp_q.size())
      $display("FAIL discard_after_writes: %0d bad, count got %0d want %0d", mism, got_q.size() - g_base, exp_q.size());
    else passed++;
    total++; if (last_good_frame_idx_o !== CB'(2)) $display("FAIL discard_after_last_good: got %0d want 2", last_good_frame_idx_o); else passed++;
  endtask

  task automatic test_sync();
    int b, mism;
    do_reset();
    for (int ch = 0; ch < 3; ch++) send_sample(24'($urandom), ch == 0, 0);
    for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, 0);
    wait_idle();
    total++; if (sync_seen - s_base !== 1) $display("FAIL sync_restart_pulse: got %0d want 1", sync_seen - s_base); else passed++;
    total++;
    if (g_base + 72 >= got_q.size() || got_q[g_base + 72][AW:1] !== {CB'(1), 3'd0, 5'd0})
      $display("FAIL sync_restart_addr: got %h want %h",
               (g_base + 72 < got_q.size()) ? got_q[g_base + 72][AW:1] : 'x, {CB'(1), 3'd0, 5'd0});
    else passed++;
    total++; if (last_good_frame_idx_o !== CB'(1)) $display("FAIL sync_last_good: got %0d want 1", last_good_frame_idx_o); else passed++;
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (g_base + i >= got_q.size() || got_q[g_base + i] !== exp_q[i]) mism++;
    total++;
    if (mism != 0 || got_q.size() - g_base != 264)
      $display("FAIL sync_writes: %0d bad, count got %0d want 264", mism, got_q.size() - g_base);
    else passed++;
    b = got_q.size();
    send_sample(24'($urandom), 1'b0, 0);
    wait_idle();
    total++; if (got_q.size() !== b) $display("FAIL sync_stray_write: got %0d want 0", got_q.size() - b); else passed++;
    total++; if (sync_seen - s_base !== 2) $display("FAIL sync_stray_pulse: got %0d want 2", sync_seen - s_base); else passed++;
  endtask

  task automatic test_random();
    int mism;
    bit first;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      first = (m_ch == 0) ? ($urandom_range(7) != 0) : ($urandom_range(9) == 0);
      send_sample(24'($urandom), first, int'($urandom_range(7)));
    end
    wait_idle();
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (g_base + i >= got_q.size() || got_q[g_base + i] !== exp_q[i]) mism++;
    total++;
    if (mism != 0 || got_q.size() - g_base != exp_q.size())
      $display("FAIL random_writes: %0d bad, count got %0d want %0d", mism, got_q.size() - g_base, exp_q.size());
    else passed++;
    total++; if (drop_seen - d_base !== m_drop) $display("FAIL random_dropped: got %0d want %0d", drop_seen - d_base, m_drop); else passed++;
    total++; if (sync_seen - s_base !== m_sync) $display("FAIL random_sync: got %0d want %0d", sync_seen - s_base, m_sync); else passed++;
    total++; if (last_good_frame_idx_o !== CB'(m_lg)) $display("FAIL random_last_good: got %0d want %0d", last_good_frame_idx_o, m_lg); else passed++;
  endtask

  task automatic test_reset_midshift();
    int n, b;
    do_reset();
    for (int ch = 0; ch < 4; ch++) send_sample(24'($urandom), ch == 0, 0);
    n = 0;
    while (got_q.size() < g_base + 83 && n < 500) begin
      @(negedge clk_i); #1;
      n++;
    end
    total++; if (n >= 500) $display("FAIL midshift_timeout: got %0d writes want 83", got_q.size() - g_base); else passed++;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    total++; if (ram_write_en_o !== 1'b0) $display("FAIL midshift_we: got %0b want 0", ram_write_en_o); else passed++;
    @(negedge clk_i);
    total++; if (last_good_frame_idx_o !== CB'(0)) $display("FAIL midshift_last_good: got %0d want 0", last_good_frame_idx_o); else passed++;
    total++; if (got_q.size() - g_base !== 83) $display("FAIL midshift_write_count: got %0d want 83", got_q.size() - g_base); else passed++;
    do_reset();
    b = got_q.size();
    for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, 0);
    wait_idle();
    total++;
    if (b >= got_q.size() || got_q[b][AW:1] !== {CB'(1), 3'd0, 5'd0})
      $display("FAIL midshift_restart_addr: got %h want %h", (b < got_q.size()) ? got_q[b][AW:1] : 'x, {CB'(1), 3'd0, 5'd0});
    else passed++;
    total++; if (last_good_frame_idx_o !== CB'(1)) $display("FAIL midshift_after_last_good: got %0d want 1", last_good_frame_idx_o); else passed++;
  endtask

`ifdef ADAT_WRITER_OVERFLOW_CNT_EN
  task automatic test_overflow();
    do_reset();
    total++; if (overflow_count_o !== 8'd0) $display("FAIL ovf_reset: got %0d want 0", overflow_count_o); else passed++;
    for (int f = 0; f < 300; f++)
      for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, 1);
    wait_idle();
    total++; if (drop_seen - d_base !== 300) $display("FAIL ovf_drops: got %0d want 300", drop_seen - d_base); else passed++;
    total++; if (overflow_count_o !== 8'd255) $display("FAIL ovf_saturate: got %0d want 255", overflow_count_o); else passed++;
    for (int ch = 0; ch < 8; ch++) send_sample(24'($urandom), ch == 0, 1);
    wait_idle();
    total++; if (overflow_count_o !== 8'd255) $display("FAIL ovf_hold: got %0d want 255", overflow_count_o); else passed++;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_wrap();
    test_discard();
    test_sync();
    test_random();
    test_reset_midshift();
`ifdef ADAT_WRITER_OVERFLOW_CNT_EN
    test_overflow();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
